// File: rtl/fcore_efi_sorter_responder_if.sv
// Stream bundle for the EFI argument and result channels (data, dest, valid, tlast, ready).
interface fcore_efi_sorter_responder_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEST_W = 8
);
  logic [DATA_W-1:0] data;
  logic [DEST_W-1:0] dest;
  logic              valid;
  logic              tlast;
  logic              ready;

  modport master (output data, output dest, output valid, output tlast, input ready);
  modport slave  (input data, input dest, input valid, input tlast, output ready);
endinterface

// File: rtl/fcore_efi_sorter_responder.sv
// EFI responder: insertion-sorts incoming arguments (signed, stable) into a local
// buffer, then streams them back in ascending order with dest = element index.
module fcore_efi_sorter_responder #(
  parameter int unsigned DATAPATH_WIDTH = 32,
  parameter int unsigned MAX_ARGS       = 16,
  parameter int unsigned DEST_WIDTH     = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  fcore_efi_sorter_responder_if.slave   efi_arguments,
  fcore_efi_sorter_responder_if.master  efi_results,
  output logic                          busy,
  output logic                          overflow,
  output logic                          protocol_error
);

  localparam int unsigned CNT_W = $clog2(MAX_ARGS + 1);
  localparam int unsigned IDX_W = (MAX_ARGS > 1) ? $clog2(MAX_ARGS) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, SEND} state_e;
  typedef logic [DATAPATH_WIDTH-1:0] word_t;

  state_e                state_q, state_d;
  word_t                 buf_q [MAX_ARGS];
  word_t                 buf_d [MAX_ARGS];
  word_t                 ins_buf [MAX_ARGS];
  logic [MAX_ARGS-1:0]   at_or_above;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      idx_q, idx_d, idx_nxt;
  logic                  res_valid_q, res_valid_d;
  logic                  res_last_q, res_last_d;
  word_t                 res_data_q, res_data_d;
  logic [DEST_WIDTH-1:0] res_dest_q, res_dest_d;
  logic                  busy_q, busy_d;
  logic                  ovf_q, ovf_d;
  logic                  perr_q, perr_d;
  word_t                 arg_c;
  logic                  room_c;
  logic                  unused_dest_c;

  assign unused_dest_c = ^efi_arguments.dest;
  assign arg_c         = efi_arguments.data;
  assign room_c        = count_q < CNT_W'(MAX_ARGS);

  // Parallel compare-and-shift: slots [pos, count] move up, the new value lands at pos.
  always_comb begin
    at_or_above = '0;
    ins_buf     = buf_q;
    for (int i = 0; i < MAX_ARGS; i++) begin
      if (CNT_W'(i) < count_q) at_or_above[i] = $signed(buf_q[i]) > $signed(arg_c);
      else                     at_or_above[i] = (CNT_W'(i) == count_q);
    end
    ins_buf[0] = at_or_above[0] ? arg_c : buf_q[0];
    for (int i = 1; i < MAX_ARGS; i++) begin
      if (!at_or_above[i])     ins_buf[i] = buf_q[i];
      else if (at_or_above[i-1]) ins_buf[i] = buf_q[i-1];
      else                     ins_buf[i] = arg_c;
    end
  end

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    count_d     = count_q;
    idx_d       = idx_q;
    idx_nxt     = idx_q + CNT_W'(1);
    res_valid_d = res_valid_q;
    res_last_d  = res_last_q;
    res_data_d  = res_data_q;
    res_dest_d  = res_dest_q;
    ovf_d       = ovf_q;
    perr_d      = perr_q;

    case (state_q)
      IDLE: begin
        if (efi_arguments.valid) begin
          ovf_d   = 1'b0;
          perr_d  = 1'b0;
          buf_d   = ins_buf;
          count_d = CNT_W'(1);
          state_d = efi_arguments.tlast ? SEND : COLLECT;
        end
      end
      COLLECT: begin
        if (efi_arguments.valid) begin
          if (room_c) begin
            buf_d   = ins_buf;
            count_d = count_q + CNT_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
          if (efi_arguments.tlast) state_d = SEND;
        end
      end
      SEND: begin
        if (efi_arguments.valid) perr_d = 1'b1;
        if (res_valid_q && efi_results.ready) begin
          if (res_last_q) begin
            state_d     = IDLE;
            count_d     = '0;
            idx_d       = '0;
            res_valid_d = 1'b0;
            res_last_d  = 1'b0;
            res_data_d  = '0;
            res_dest_d  = '0;
          end else begin
            idx_d      = idx_nxt;
            res_data_d = buf_q[IDX_W'(idx_nxt)];
            res_dest_d = DEST_WIDTH'(idx_nxt);
            res_last_d = (idx_nxt == count_q - CNT_W'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Present the first result in the cycle right after the tlast beat.
    if (state_q != SEND && state_d == SEND) begin
      idx_d       = '0;
      res_valid_d = 1'b1;
      res_data_d  = buf_d[0];
      res_dest_d  = '0;
      res_last_d  = (count_d == CNT_W'(1));
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      for (int i = 0; i < MAX_ARGS; i++) buf_q[i] <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      res_data_q  <= '0;
      res_dest_q  <= '0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      res_valid_q <= res_valid_d;
      res_last_q  <= res_last_d;
      res_data_q  <= res_data_d;
      res_dest_q  <= res_dest_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
      perr_q      <= perr_d;
    end
  end

  assign efi_arguments.ready = 1'b1;
  assign efi_results.valid   = res_valid_q;
  assign efi_results.tlast   = res_last_q;
  assign efi_results.data    = res_data_q;
  assign efi_results.dest    = res_dest_q;
  assign busy                = busy_q;
  assign overflow            = ovf_q;
  assign protocol_error      = perr_q;

endmodule

// File: tb/tb_fcore_efi_sorter_responder.sv
// Directed bench for fcore_efi_sorter_responder with hand-computed sorted results.
module tb_fcore_efi_sorter_responder;

  logic clock;
  logic reset;
  logic busy, overflow, protocol_error;

  fcore_efi_sorter_responder_if #(.DATA_W(32), .DEST_W(8)) arg_if ();
  fcore_efi_sorter_responder_if #(.DATA_W(32), .DEST_W(8)) res_if ();

  fcore_efi_sorter_responder #(
    .DATAPATH_WIDTH(32), .MAX_ARGS(16), .DEST_WIDTH(8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .efi_arguments  (arg_if),
    .efi_results    (res_if),
    .busy           (busy),
    .overflow       (overflow),
    .protocol_error (protocol_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks;
  int failures;

  logic [31:0] args     [32];
  logic [31:0] exp_data [32];
  logic        rpat     [16];
  int          rpat_n;
  int          inj_cyc;

  logic [31:0] obs_data [32];
  logic [7:0]  obs_dest [32];
  logic        obs_last [32];
  logic        busy_at  [64];
  int          obs_n;
  int          first_valid;
  int          stable_viol;
  int          stall_cycles;
  logic        post_valid, post_busy, timed_out;

  task automatic drive_args(input int n, input logic with_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      arg_if.valid = 1'b1;
      arg_if.data  = args[i];
      arg_if.dest  = 8'(i + 8'h40);
      arg_if.tlast = with_last && (i == n - 1);
      @(posedge clock);
      #1;
      arg_if.valid = 1'b0;
      arg_if.tlast = 1'b0;
    end
  endtask

  // Observe the result stream until the tlast handshake (or budget), then one more cycle.
  task automatic capture(input int budget);
    logic        held;
    logic [31:0] held_data;
    logic [7:0]  held_dest;
    logic        got_last;
    held = 1'b0; held_data = '0; held_dest = '0; got_last = 1'b0;
    obs_n = 0; first_valid = -1; stable_viol = 0; stall_cycles = 0;
    for (int cyc = 0; cyc < budget && !got_last; cyc++) begin
      @(negedge clock);
      res_if.ready = (cyc < rpat_n) ? rpat[cyc] : 1'b1;
      arg_if.valid = (cyc == inj_cyc);
      arg_if.data  = (cyc == inj_cyc) ? 32'd99 : 32'd0;
      if (cyc < 64) busy_at[cyc] = busy;
      if (res_if.valid && first_valid < 0) first_valid = cyc;
      if (held && (res_if.data !== held_data || res_if.dest !== held_dest)) stable_viol++;
      held      = res_if.valid && !res_if.ready;
      held_data = res_if.data;
      held_dest = res_if.dest;
      if (held) stall_cycles++;
      if (res_if.valid && res_if.ready) begin
        if (obs_n < 32) begin
          obs_data[obs_n] = res_if.data;
          obs_dest[obs_n] = res_if.dest;
          obs_last[obs_n] = res_if.tlast;
        end
        obs_n++;
        if (res_if.tlast) got_last = 1'b1;
      end
    end
    @(negedge clock);
    arg_if.valid = 1'b0;
    res_if.ready = 1'b1;
    post_valid   = res_if.valid;
    post_busy    = busy;
    timed_out    = !got_last;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (res_if.valid !== 1'b0 || res_if.tlast !== 1'b0 || res_if.data !== 32'd0 || res_if.dest !== 8'd0) begin
      failures++;
      $display("FAIL reset_results got v=%b l=%b d=%0h dst=%0h want all 0", res_if.valid, res_if.tlast, res_if.data, res_if.dest);
    end
    checks++;
    if (arg_if.ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got %b want 1", arg_if.ready);
    end
    checks++;
    if ({busy, overflow, protocol_error} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got %b want 000", {busy, overflow, protocol_error});
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_basic_sort;
    args[0] = 32'd5; args[1] = 32'hFFFF_FFFD; args[2] = 32'd12; args[3] = 32'd0;
    exp_data[0] = 32'hFFFF_FFFD; exp_data[1] = 32'd0; exp_data[2] = 32'd5; exp_data[3] = 32'd12;
    drive_args(4, 1'b1);
    capture(20);
    checks++;
    if (timed_out !== 1'b0 || obs_n !== 4) begin
      failures++; $display("FAIL basic_count got %0d beats (timeout=%b) want 4", obs_n, timed_out);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_data[k] !== exp_data[k] || obs_dest[k] !== 8'(k) || obs_last[k] !== (k == 3)) begin
        failures++;
        $display("FAIL basic_beat[%0d] got d=%0h dst=%0d l=%b want d=%0h dst=%0d l=%b",
                 k, obs_data[k], obs_dest[k], obs_last[k], exp_data[k], k, (k == 3));
      end
    end
    checks++;
    if (first_valid !== 0) begin
      failures++; $display("FAIL basic_latency got first valid at cycle %0d want 0", first_valid);
    end
    checks++;
    if ({busy_at[0], busy_at[1], busy_at[2], busy_at[3], post_busy, post_valid} !== 6'b111100) begin
      failures++;
      $display("FAIL basic_busy got %b want 111100",
               {busy_at[0], busy_at[1], busy_at[2], busy_at[3], post_busy, post_valid});
    end
  endtask

  task automatic test_stable_ties;
    args[0] = 32'd7; args[1] = 32'd7; args[2] = 32'd2;
    exp_data[0] = 32'd2; exp_data[1] = 32'd7; exp_data[2] = 32'd7;
    drive_args(3, 1'b1);
    capture(20);
    checks++;
    if (obs_n !== 3 || timed_out !== 1'b0) begin
      failures++; $display("FAIL ties_count got %0d want 3", obs_n);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_data[k] !== exp_data[k] || obs_dest[k] !== 8'(k) || obs_last[k] !== (k == 2)) begin
        failures++;
        $display("FAIL ties_beat[%0d] got d=%0h dst=%0d l=%b want d=%0h dst=%0d", k, obs_data[k], obs_dest[k], obs_last[k], exp_data[k], k);
      end
    end
  endtask

  task automatic test_single_arg;
    args[0] = 32'h7FFF_FFFF;
    drive_args(1, 1'b1);
    capture(10);
    checks++;
    if (obs_n !== 1 || obs_data[0] !== 32'h7FFF_FFFF || obs_dest[0] !== 8'd0 || obs_last[0] !== 1'b1) begin
      failures++;
      $display("FAIL single_beat got n=%0d d=%0h dst=%0d l=%b want n=1 d=7fffffff dst=0 l=1", obs_n, obs_data[0], obs_dest[0], obs_last[0]);
    end
    checks++;
    if (post_valid !== 1'b0 || post_busy !== 1'b0) begin
      failures++; $display("FAIL single_idle got v=%b busy=%b want 0 0", post_valid, post_busy);
    end
  endtask

  task automatic test_back_pressure;
    args[0] = 32'd30; args[1] = 32'd10; args[2] = 32'd20;
    exp_data[0] = 32'd10; exp_data[1] = 32'd20; exp_data[2] = 32'd30;
    rpat[0] = 1'b1; rpat[1] = 1'b0; rpat[2] = 1'b0; rpat[3] = 1'b1; rpat[4] = 1'b1;
    rpat_n = 5;
    drive_args(3, 1'b1);
    capture(20);
    rpat_n = 0;
    checks++;
    if (obs_n !== 3 || timed_out !== 1'b0 || post_valid !== 1'b0) begin
      failures++; $display("FAIL bp_count got %0d beats post_valid=%b want 3 and 0", obs_n, post_valid);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_data[k] !== exp_data[k] || obs_dest[k] !== 8'(k) || obs_last[k] !== (k == 2)) begin
        failures++;
        $display("FAIL bp_beat[%0d] got d=%0h dst=%0d l=%b want d=%0h dst=%0d", k, obs_data[k], obs_dest[k], obs_last[k], exp_data[k], k);
      end
    end
    checks++;
    if (stable_viol !== 0 || stall_cycles !== 2) begin
      failures++; $display("FAIL bp_stable got violations=%0d stalls=%0d want 0 and 2", stable_viol, stall_cycles);
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 18; i++) args[i] = 32'(i + 1);
    drive_args(18, 1'b1);
    checks++;
    if (overflow !== 1'b1) begin
      failures++; $display("FAIL ovf_flag got %b want 1", overflow);
    end
    capture(40);
    checks++;
    if (obs_n !== 16 || timed_out !== 1'b0) begin
      failures++; $display("FAIL ovf_count got %0d want 16", obs_n);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (obs_data[k] !== 32'(k + 1) || obs_dest[k] !== 8'(k) || obs_last[k] !== (k == 15)) begin
        failures++;
        $display("FAIL ovf_beat[%0d] got d=%0h dst=%0d l=%b want d=%0h dst=%0d", k, obs_data[k], obs_dest[k], obs_last[k], k + 1, k);
      end
    end
    args[0] = 32'd4; args[1] = 32'd2;
    drive_args(2, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      failures++; $display("FAIL ovf_clear got %b want 0", overflow);
    end
    capture(10);
    checks++;
    if (obs_n !== 2 || obs_data[0] !== 32'd2 || obs_data[1] !== 32'd4 || obs_last[1] !== 1'b1) begin
      failures++; $display("FAIL ovf_next_call got n=%0d d0=%0h d1=%0h want 2 2 4", obs_n, obs_data[0], obs_data[1]);
    end
  endtask

  task automatic test_protocol_error;
    args[0] = 32'd3; args[1] = 32'd1; args[2] = 32'd2;
    drive_args(3, 1'b1);
    checks++;
    if (protocol_error !== 1'b0) begin
      failures++; $display("FAIL perr_pre got %b want 0", protocol_error);
    end
    inj_cyc = 1;
    capture(20);
    inj_cyc = -1;
    checks++;
    if (protocol_error !== 1'b1) begin
      failures++; $display("FAIL perr_flag got %b want 1", protocol_error);
    end
    checks++;
    if (obs_n !== 3 || post_busy !== 1'b0 || post_valid !== 1'b0) begin
      failures++; $display("FAIL perr_count got n=%0d busy=%b valid=%b want 3 0 0", obs_n, post_busy, post_valid);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_data[k] !== 32'(k + 1) || obs_dest[k] !== 8'(k) || obs_last[k] !== (k == 2)) begin
        failures++;
        $display("FAIL perr_beat[%0d] got d=%0h dst=%0d l=%b want d=%0h dst=%0d", k, obs_data[k], obs_dest[k], obs_last[k], k + 1, k);
      end
    end
  endtask

  task automatic test_reset_mid_call;
    args[0] = 32'd50; args[1] = 32'd40;
    drive_args(2, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL mid_busy got %b want 1", busy);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, overflow, protocol_error, res_if.valid, res_if.tlast} !== 5'b00000 ||
        res_if.data !== 32'd0 || res_if.dest !== 8'd0 || arg_if.ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset got flags=%b d=%0h dst=%0h rdy=%b want 00000 0 0 1",
               {busy, overflow, protocol_error, res_if.valid, res_if.tlast}, res_if.data, res_if.dest, arg_if.ready);
    end
    @(negedge clock);
    reset = 1'b1;
    args[0] = 32'd9; args[1] = 32'd1;
    drive_args(2, 1'b1);
    capture(10);
    checks++;
    if (obs_n !== 2 || timed_out !== 1'b0) begin
      failures++; $display("FAIL mid_count got %0d want 2", obs_n);
    end
    checks++;
    if (obs_data[0] !== 32'd1 || obs_dest[0] !== 8'd0 || obs_data[1] !== 32'd9 || obs_dest[1] !== 8'd1 || obs_last[1] !== 1'b1) begin
      failures++;
      $display("FAIL mid_results got %0h/%0d %0h/%0d want 1/0 9/1", obs_data[0], obs_dest[0], obs_data[1], obs_dest[1]);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    arg_if.valid = 1'b0; arg_if.data = '0; arg_if.dest = '0; arg_if.tlast = 1'b0;
    res_if.ready = 1'b1;
    rpat_n = 0; inj_cyc = -1;
    reset = 1'b0;
    test_reset;
    test_basic_sort;
    test_stable_ties;
    test_single_arg;
    test_back_pressure;
    test_overflow;
    test_protocol_error;
    test_reset_mid_call;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
